// File: rtl/core_pkg.sv
// Shared core constants: instruction-word field layout, common widths and
// the reservation-station state encoding.
package core_pkg;

    localparam int INST_W = 114;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    localparam int RD_LSB   = 0;
    localparam int S1V_BIT  = 5;
    localparam int S1_LSB   = 6;
    localparam int S2V_BIT  = 38;
    localparam int S2_LSB   = 39;
    localparam int CTRL_LSB = 71;

    localparam int RD_W = S1V_BIT - RD_LSB;

    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2
    } rs_state_t;

endpackage

// File: rtl/rs_operand_slot.sv
// One source operand of a reservation-station entry: value/valid storage with
// dispatch load and CDB wakeup. A pending operand keeps its producer tag in the low bits.
module rs_operand_slot
    import core_pkg::*;
#(
    parameter int TAG_W  = core_pkg::TAG_W,
    parameter int DATA_W = core_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic              load_valid,
    input  logic              snoop,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_value,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_value,
    output logic [DATA_W-1:0] value,
    output logic              valid,
    output logic              valid_next
);

    logic [DATA_W-1:0] base_value;
    logic              base_valid;
    logic [TAG_W-1:0]  wait_tag;
    logic              pending;
    logic [DATA_W-1:0] value_d;
    logic              valid_d;

    // Capture is checked against the incoming word on a load so a broadcast in
    // the dispatch cycle is not missed.
    always_comb begin
        base_value = load ? load_value : value;
        base_valid = load ? load_valid : valid;
        wait_tag   = base_value[TAG_W-1:0];
        pending    = (load || snoop) && !base_valid;
        value_d    = base_value;
        valid_d    = base_valid;
        if (pending) begin
            if (cdb0_valid && (cdb0_tag == wait_tag)) begin
                value_d = cdb0_value;
                valid_d = 1'b1;
            end else if (cdb1_valid && (cdb1_tag == wait_tag)) begin
                value_d = cdb1_value;
                valid_d = 1'b1;
            end
        end
    end

    assign valid_next = valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            valid <= 1'b0;
        end else begin
            value <= value_d;
            valid <= valid_d;
        end
    end

endmodule

// File: rtl/rs_entry.sv
// Single-entry reservation station: holds one dispatched instruction until both
// operands are captured from the CDB, then issues it with a valid/ready handshake.
//
//   state    | meaning
//   RS_EMPTY | slot free, accepts dispatch
//   RS_WAIT  | occupied, at least one operand pending on the CDB
//   RS_READY | both operands valid, offered to the functional unit
module rs_entry
    import core_pkg::*;
#(
    parameter int INST_W = core_pkg::INST_W,
    parameter int TAG_W  = core_pkg::TAG_W,
    parameter int DATA_W = core_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [INST_W-1:0] disp_data,
    input  logic [TAG_W-1:0]  disp_entry_num,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_value,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_value,
    output logic              empty,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [INST_W-1:0] issue_data,
    output logic [TAG_W-1:0]  issue_rob_tag,
    output logic              disp_err
);

    localparam int CTRL_W = INST_W - CTRL_LSB;

    rs_state_t         state;
    logic [CTRL_W-1:0] ctrl_q;
    logic [RD_W-1:0]   rd_q;
    logic [TAG_W-1:0]  tag_q;

    logic              load;
    logic              snoop;
    logic [DATA_W-1:0] s1_value, s2_value;
    logic              s1_valid, s2_valid;
    logic              s1_valid_next, s2_valid_next;
    logic              both_next;

    assign load      = (state == RS_EMPTY) && disp_valid && !flush;
    assign snoop     = (state == RS_WAIT) && !flush;
    assign both_next = s1_valid_next && s2_valid_next;

    rs_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (disp_data[S1_LSB +: DATA_W]),
        .load_valid (disp_data[S1V_BIT]),
        .snoop      (snoop),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb0_value (cdb0_value),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_value (cdb1_value),
        .value      (s1_value),
        .valid      (s1_valid),
        .valid_next (s1_valid_next)
    );

    rs_operand_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_s2 (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (disp_data[S2_LSB +: DATA_W]),
        .load_valid (disp_data[S2V_BIT]),
        .snoop      (snoop),
        .cdb0_valid (cdb0_valid),
        .cdb0_tag   (cdb0_tag),
        .cdb0_value (cdb0_value),
        .cdb1_valid (cdb1_valid),
        .cdb1_tag   (cdb1_tag),
        .cdb1_value (cdb1_value),
        .value      (s2_value),
        .valid      (s2_valid),
        .valid_next (s2_valid_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RS_EMPTY;
            ctrl_q   <= '0;
            rd_q     <= '0;
            tag_q    <= '0;
            disp_err <= 1'b0;
        end else begin
            disp_err <= 1'b0;
            if (flush) begin
                state <= RS_EMPTY;
            end else begin
                case (state)
                    RS_EMPTY: begin
                        if (disp_valid) begin
                            ctrl_q <= disp_data[CTRL_LSB +: CTRL_W];
                            rd_q   <= disp_data[RD_LSB +: RD_W];
                            tag_q  <= disp_entry_num;
                            state  <= both_next ? RS_READY : RS_WAIT;
                        end
                    end
                    RS_WAIT: begin
                        disp_err <= disp_valid;
                        if (both_next) state <= RS_READY;
                    end
                    RS_READY: begin
                        disp_err <= disp_valid;
                        if (issue_ready) state <= RS_EMPTY;
                    end
                    default: state <= RS_EMPTY;
                endcase
            end
        end
    end

    // Outputs decode registered state only; nothing from issue_ready reaches empty.
    assign empty         = (state == RS_EMPTY);
    assign issue_valid   = (state == RS_READY);
    assign issue_rob_tag = tag_q;
    assign issue_data    = {ctrl_q, s2_value, s2_valid, s1_value, s1_valid, rd_q};

endmodule

// File: tb/tb_rs_entry.sv
// Bench for rs_entry: directed vector table, a stall/flush sequence and a
// randomized run checked against an occupancy/operand-readiness model.
module tb_rs_entry;

    localparam int IW = 114;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [42:0] C  = 43'h2A5_A5A5_A5A5;
    localparam logic [4:0]  RD = 5'h13;

    logic          clk = 1'b0;
    logic          rst, flush, disp_valid;
    logic [IW-1:0] disp_data;
    logic [TW-1:0] disp_entry_num;
    logic          cdb0_valid, cdb1_valid;
    logic [TW-1:0] cdb0_tag, cdb1_tag;
    logic [DW-1:0] cdb0_value, cdb1_value;
    logic          empty, issue_valid, issue_ready, disp_err;
    logic [IW-1:0] issue_data;
    logic [TW-1:0] issue_rob_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rs_entry dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_data      (disp_data),
        .disp_entry_num (disp_entry_num),
        .cdb0_valid     (cdb0_valid),
        .cdb0_tag       (cdb0_tag),
        .cdb0_value     (cdb0_value),
        .cdb1_valid     (cdb1_valid),
        .cdb1_tag       (cdb1_tag),
        .cdb1_value     (cdb1_value),
        .empty          (empty),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_data     (issue_data),
        .issue_rob_tag  (issue_rob_tag),
        .disp_err       (disp_err)
    );

    function automatic logic [IW-1:0] mk_word(input logic [42:0] c, input logic [31:0] s2,
                                              input logic v2, input logic [31:0] s1,
                                              input logic v1, input logic [4:0] rd);
        return {c, s2, v2, s1, v1, rd};
    endfunction

    function automatic logic [IW-1:0] w(input logic [31:0] s2, input logic [31:0] s1);
        return mk_word(C, s2, Y, s1, Y, RD);
    endfunction

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string         name;
        logic          r, f, dv;
        logic [3:0]    tg;
        logic [31:0]   s1;
        logic          v1;
        logic [31:0]   s2;
        logic          v2;
        logic          c0v;
        logic [3:0]    c0t;
        logic [31:0]   c0d;
        logic          c1v;
        logic [3:0]    c1t;
        logic [31:0]   c1d;
        logic          ir;
        logic          e_empty, e_iv, e_err;
        logic          chk_tag;
        logic [3:0]    e_tag;
        logic          chk_data;
        logic [IW-1:0] e_data;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input string nm, input logic r, input logic f, input logic dv,
                                input logic [3:0] tg, input logic [31:0] s1, input logic v1,
                                input logic [31:0] s2, input logic v2,
                                input logic c0v, input logic [3:0] c0t, input logic [31:0] c0d,
                                input logic c1v, input logic [3:0] c1t, input logic [31:0] c1d,
                                input logic ir, input logic ee, input logic eiv, input logic eer,
                                input logic ct, input logic [3:0] et,
                                input logic cd, input logic [IW-1:0] ed);
        vec_t v;
        v.name = nm; v.r = r; v.f = f; v.dv = dv; v.tg = tg;
        v.s1 = s1; v.v1 = v1; v.s2 = s2; v.v2 = v2;
        v.c0v = c0v; v.c0t = c0t; v.c0d = c0d;
        v.c1v = c1v; v.c1t = c1t; v.c1d = c1d;
        v.ir = ir; v.e_empty = ee; v.e_iv = eiv; v.e_err = eer;
        v.chk_tag = ct; v.e_tag = et; v.chk_data = cd; v.e_data = ed;
        vq.push_back(v);
    endfunction

    task automatic idle_inputs();
        rst = N; flush = N; disp_valid = N; disp_data = '0; disp_entry_num = '0;
        cdb0_valid = N; cdb0_tag = '0; cdb0_value = '0;
        cdb1_valid = N; cdb1_tag = '0; cdb1_value = '0;
        issue_ready = N;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an occupied flag plus per-operand ready/value, updated per edge.
    logic          m_full, m_v1, m_v2, m_err;
    logic [31:0]   m_s1, m_s2;
    logic [3:0]    m_tag;
    logic [42:0]   m_ctrl;
    logic [4:0]    m_rd;

    task automatic wake(inout logic [31:0] s, inout logic v);
        if (!v) begin
            if (cdb0_valid && cdb0_tag == s[3:0]) begin
                s = cdb0_value; v = Y;
            end else if (cdb1_valid && cdb1_tag == s[3:0]) begin
                s = cdb1_value; v = Y;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_full = N; m_v1 = N; m_v2 = N; m_err = N;
            m_s1 = '0; m_s2 = '0; m_tag = '0; m_ctrl = '0; m_rd = '0;
        end else if (flush) begin
            m_full = N; m_err = N;
        end else if (!m_full) begin
            m_err = N;
            if (disp_valid) begin
                m_full = Y;
                m_tag  = disp_entry_num;
                m_ctrl = disp_data[113:71];
                m_rd   = disp_data[4:0];
                m_s1   = disp_data[37:6];  m_v1 = disp_data[5];
                m_s2   = disp_data[70:39]; m_v2 = disp_data[38];
                wake(m_s1, m_v1);
                wake(m_s2, m_v2);
            end
        end else begin
            m_err = disp_valid;
            if (m_v1 && m_v2) begin
                if (issue_ready) m_full = N;
            end else begin
                wake(m_s1, m_v1);
                wake(m_s2, m_v2);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = Y;

        //  name             r  f  dv tag    s1              v1 s2            v2 c0v c0t    c0d            c1v c1t    c1d            ir ee eiv eer ct et     cd ed
        add("reset",         Y, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, Y, N, N, Y, 4'd0, Y, '0);
        add("rdy_disp",      N, N, Y, 4'd3, 32'h11,         Y, 32'h22,       Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, N, Y, N, Y, 4'd3, Y, w(32'h22, 32'h11));
        add("rdy_free",      N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, N, N, 4'd0, N, '0);
        add("wk_disp",       N, N, Y, 4'd5, 32'h2,          N, 32'h7,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd5, N, '0);
        add("wk_cdb0",       N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, Y, 4'd2, 32'hAAAA,      N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd5, N, '0);
        add("wk_gap",        N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd5, N, '0);
        add("wk_cdb1",       N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         Y, 4'd7, 32'h5555,      N, N, Y, N, Y, 4'd5, Y, w(32'h5555, 32'hAAAA));
        add("wk_free",       N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, N, N, 4'd0, N, '0);
        add("same_cycle",    N, N, Y, 4'd9, 32'h4,          N, 32'h77,       Y, N, 4'd0, 32'h0,         Y, 4'd4, 32'h1234,      N, N, Y, N, Y, 4'd9, Y, w(32'h77, 32'h1234));
        add("same_free",     N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, N, N, 4'd0, N, '0);
        add("cdb0_wins",     N, N, Y, 4'd6, 32'h8,          N, 32'h33,       Y, Y, 4'd8, 32'hC0C0,      Y, 4'd8, 32'hC1C1,      N, N, Y, N, Y, 4'd6, Y, w(32'h33, 32'hC0C0));
        add("wins_free",     N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, N, N, 4'd0, N, '0);
        add("both_pend",     N, N, Y, 4'd1, 32'hFFFF_000A,  N, 32'h1234_567A, N, N, 4'd0, 32'h0,        N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd1, N, '0);
        add("no_match",      N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, Y, 4'hB, 32'h1,         Y, 4'hC, 32'h2,         Y, N, N, N, Y, 4'd1, N, '0);
        add("both_wake",     N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, Y, 4'hA, 32'hBEEF,      N, 4'd0, 32'h0,         N, N, Y, N, Y, 4'd1, Y, w(32'hBEEF, 32'hBEEF));
        add("both_free",     N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, N, N, 4'd0, N, '0);
        add("occ_disp",      N, N, Y, 4'd2, 32'h1,          N, 32'h44,       Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd2, N, '0);
        add("occ_err",       N, N, Y, 4'hF, 32'h5,          Y, 32'h6,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, Y, Y, 4'd2, N, '0);
        add("occ_err_end",   N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd2, N, '0);
        add("rst_in_wait",   Y, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, Y, N, N, Y, 4'd0, Y, '0);
        add("flush_empty",   N, Y, Y, 4'd3, 32'h1,          Y, 32'h2,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, Y, N, N, N, 4'd0, N, '0);
        add("fw_disp",       N, N, Y, 4'd4, 32'h9,          N, 32'h2,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, N, N, Y, 4'd4, N, '0);
        add("flush_wait",    N, Y, Y, 4'd7, 32'h1,          Y, 32'h2,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, Y, N, N, N, 4'd0, N, '0);
        add("rd_disp",       N, N, Y, 4'hC, 32'h1,          Y, 32'h2,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, N, Y, N, Y, 4'hC, Y, w(32'h2, 32'h1));
        add("rd_err_issue",  N, N, Y, 4'hD, 32'h3,          Y, 32'h4,        Y, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         Y, Y, N, Y, N, 4'd0, N, '0);
        add("rd_err_end",    N, N, N, 4'd0, 32'h0,          N, 32'h0,        N, N, 4'd0, 32'h0,         N, 4'd0, 32'h0,         N, Y, N, N, N, 4'd0, N, '0);

        foreach (vq[i]) begin
            rst = vq[i].r; flush = vq[i].f; disp_valid = vq[i].dv;
            disp_entry_num = vq[i].tg;
            disp_data = mk_word(C, vq[i].s2, vq[i].v2, vq[i].s1, vq[i].v1, RD);
            cdb0_valid = vq[i].c0v; cdb0_tag = vq[i].c0t; cdb0_value = vq[i].c0d;
            cdb1_valid = vq[i].c1v; cdb1_tag = vq[i].c1t; cdb1_value = vq[i].c1d;
            issue_ready = vq[i].ir;
            step();
            chk({vq[i].name, ".empty"}, empty, vq[i].e_empty);
            chk({vq[i].name, ".issue_valid"}, issue_valid, vq[i].e_iv);
            chk({vq[i].name, ".disp_err"}, disp_err, vq[i].e_err);
            if (vq[i].chk_tag) chk({vq[i].name, ".rob_tag"}, issue_rob_tag, vq[i].e_tag);
            if (vq[i].chk_data) chk({vq[i].name, ".issue_data"}, issue_data, vq[i].e_data);
        end

        // Stall in READY for five cycles, then flush together with issue_ready.
        idle_inputs();
        disp_valid = Y; disp_entry_num = 4'hE;
        disp_data = mk_word(C, 32'h2222, Y, 32'h1111, Y, RD);
        step();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall.issue_valid", issue_valid, Y);
            chk("stall.empty", empty, N);
            chk("stall.rob_tag", issue_rob_tag, 4'hE);
            chk("stall.issue_data", issue_data, w(32'h2222, 32'h1111));
        end
        flush = Y; issue_ready = Y;
        step();
        idle_inputs();
        chk("stall_flush.empty", empty, Y);
        chk("stall_flush.issue_valid", issue_valid, N);
        chk("stall_flush.disp_err", disp_err, N);

        // Randomized run against the model.
        idle_inputs();
        rst = Y;
        model_step();
        step();
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] r64;
            logic [31:0] s1r, s2r;
            r64 = {$urandom(), $urandom()};
            s1r = $urandom();
            s2r = $urandom();
            s1r[3:0] = 4'($urandom_range(0, 5));
            s2r[3:0] = 4'($urandom_range(0, 5));
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 31) == 0);
            disp_valid = ($urandom_range(0, 2) == 0);
            disp_entry_num = 4'($urandom_range(0, 15));
            disp_data = mk_word(r64[42:0], s2r, 1'($urandom_range(0, 1)),
                                s1r, 1'($urandom_range(0, 1)), r64[47:43]);
            cdb0_valid = ($urandom_range(0, 1) == 1);
            cdb0_tag = 4'($urandom_range(0, 5));
            cdb0_value = $urandom();
            cdb1_valid = ($urandom_range(0, 1) == 1);
            cdb1_tag = 4'($urandom_range(0, 5));
            cdb1_value = $urandom();
            issue_ready = ($urandom_range(0, 1) == 1);
            model_step();
            step();
            chk("rnd.empty", empty, !m_full);
            chk("rnd.issue_valid", issue_valid, m_full && m_v1 && m_v2);
            chk("rnd.disp_err", disp_err, m_err);
            if (m_full) chk("rnd.rob_tag", issue_rob_tag, m_tag);
            if (m_full && m_v1 && m_v2)
                chk("rnd.issue_data", issue_data, mk_word(m_ctrl, m_s2, Y, m_s1, Y, m_rd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_entry.md
# rs_entry

Single-entry reservation station slot that receives one instruction from the dispatch stage and holds it until both operands are available. Source operands are captured from the two common-data-bus (CDB) broadcast ports. Once both operands are ready, the slot issues to its functional unit through a valid/ready handshake. Six instances sit between dispatch and the execute units (complex 0/1, simple 0/1, fp 0/1). Each instance drives the matching `*_empty_*` input of dispatch and consumes the matching `*_data` / `*_entry_num` / `*_valid` outputs.

## Interface
- `INST_W`, 114, width of the dispatched instruction word (dispatch-control bits already stripped)
- `TAG_W`, 4, ROB tag width
- `DATA_W`, 32, operand width
- `clk` input 1: rising-edge clock
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `flush` input 1: squash; discards any held instruction
- `disp_valid` input 1: dispatch writes this slot this cycle
- `disp_data` input INST_W: instruction word `{ctrl[113:71], s2[70:39], s2_valid[38], s1[37:6], s1_valid[5], rd[4:0]}`
- `disp_entry_num` input TAG_W: ROB tag of the instruction
- `cdb0_valid`, `cdb1_valid` input 1: broadcast strobes
- `cdb0_tag`, `cdb1_tag` input TAG_W: ROB tag of the producer being broadcast
- `cdb0_value`, `cdb1_value` input DATA_W: broadcast result
- `empty` output 1: slot free; feeds dispatch `*_empty_*`
- `issue_valid` output 1: both operands ready, instruction offered to the functional unit
- `issue_ready` input 1: functional unit accepts this cycle
- `issue_data` output INST_W: held word with `s1`/`s2` resolved and both valid bits set to 1
- `issue_rob_tag` output TAG_W: held ROB tag
- `disp_err` output 1: one-cycle pulse when `disp_valid` arrives while `empty`=0

## Operation
- **Operand encoding.** When `sN_valid`=0, `sN[TAG_W-1:0]` holds the producer ROB tag and the upper bits are don't-care.
- **States.**
  - EMPTY (reset state)
  - WAIT: at least one operand pending
  - READY: both operands valid
- **EMPTY.** On `disp_valid`, latch the word and the tag.
  - Go to READY if both operands are valid after same-cycle CDB capture; otherwise go to WAIT.
- **Same-cycle capture.** A pending operand whose tag matches a CDB broadcast in the dispatch cycle latches that value at the same edge. This prevents a missed wakeup.
- **WAIT.** Each cycle, every pending operand compares its tag against both CDB ports.
  - On a match, latch the value and set its valid bit.
  - If both ports match the same operand, cdb0 wins. The two ports never carry the same tag legally.
  - Go to READY on the edge where the last pending operand is captured.
- **READY.** `issue_valid`=1.
  - On `issue_valid && issue_ready`, go to EMPTY.
  - Otherwise hold. All outputs stay stable while stalled.
- **Dispatch into an occupied slot.** Ignored. Held state is unchanged and `disp_err` pulses.
- **Flush.** `flush`=1 forces EMPTY at the next edge from any state.
  - Flush has priority over dispatch and over the issue handshake.
  - A `disp_valid` in the flush cycle is dropped with no `disp_err`.
- **Reset.** `rst` has priority over everything.
- **Control field.** `ctrl` bits are opaque and passed through unchanged.

## Timing
- **Reset values.**
  - `empty`=1
  - `issue_valid`=0
  - `disp_err`=0
  - `issue_data`=0
  - `issue_rob_tag`=0
- **Empty.** `empty` is decoded from registered state only (state==EMPTY). There is no combinational path from `issue_ready`, so a slot freed by issue becomes visible to dispatch one cycle later.
- **Minimum latency.** Dispatch at edge N with both operands valid gives `issue_valid`=1 in cycle N+1.
- **Wakeup latency.** CDB match at edge M on the last pending operand gives `issue_valid`=1 in cycle M+1.
- **Throughput.** At most one instruction every 2 cycles per slot: dispatch, then issue/free.
- **Error pulse.** `disp_err` is registered and asserted for exactly one cycle.

## Structure
- **Shared package `core_pkg`.**
  - Field offsets: `RD_LSB`, `S1V_BIT`, `S1_LSB`, `S2V_BIT`, `S2_LSB`, `CTRL_LSB`
  - Width constants `INST_W`, `TAG_W`, `DATA_W`, also used by dispatch and the ROB
  - State encoding `RS_EMPTY`, `RS_WAIT`, `RS_READY`
- **Sub-module `rs_operand_slot`**, instantiated twice (s1, s2).
  - Holds the value and valid bit, and performs tag compare and capture against both CDB ports.
  - Takes a load interface for the dispatch write.
  - Outputs the value and valid bit.

## Test plan
- **Ready at dispatch.** Reset, then dispatch tag 3 with s1=0x11, s2=0x22, both valid, and `issue_ready`=1 → `issue_valid` in the next cycle with `issue_rob_tag`=3. Slot returns to `empty`=1 one cycle after the handshake.
- **Wakeup from both ports.** Dispatch tag 5 with s1 pending on tag 2 and s2 pending on tag 7. Broadcast cdb0 tag 2 = 0xAAAA, then two cycles later cdb1 tag 7 = 0x5555 → `issue_valid` rises the cycle after the second broadcast. `issue_data` shows s1=0xAAAA, s2=0x5555, both valid bits 1.
- **Same-cycle wakeup.** Dispatch s1 pending on tag 4 while cdb1 broadcasts tag 4 = 0x1234 in the same cycle → READY directly, with s1=0x1234.
- **Stall then flush.** Hold `issue_ready`=0 for 5 cycles in READY → outputs stable and `empty`=0. Assert `flush` together with `issue_ready`=1 → EMPTY next cycle and no issue is counted.
- **Dispatch into occupied slot.** Dispatch while in WAIT → `disp_err` one-cycle pulse and held tag unchanged. Then assert `rst` mid-WAIT → all outputs at reset values the next cycle.
